ldpc_layer_sched: RTL and testbench

- Parametrised layered-decoding scheduler for the 802.11ay LDPC decoder. It is the successor of the fixed eight-layer, rate-1/2-only engine FSM.
- Sequences LLR copy, per-layer check-node processing and variable-node update, and tracks iterations.
- The layer count comes from the selected code rate. Check-node and variable-node dwell times are set at run time.
- Adds convergence-based early termination and a done/acknowledge handshake towards the output stage.

---
 rtl/ldpc_layer_sched_pkg.sv | 36 +++
 rtl/ldpc_layer_sched_dwell_cnt.sv | 45 ++++
 rtl/ldpc_layer_sched.sv | 191 +++++++++++++++++++
 tb/tb_ldpc_layer_sched.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_layer_sched_pkg.sv
// ---------------------------------------------------------------------------
// ldpc_layer_sched_pkg
// Shared LDPC decoder parameters for the layered scheduler:
//   - rate_e          : code-rate selector encoding (1/2, 5/8, 3/4, 13/16)
//   - LAYERS_PER_RATE : number of check-node layers for each code rate
//   - sched_state_e   : scheduler FSM states
//   - WIDTH_RATE/WIDTH_LAT : default widths of the rate and dwell inputs
// ---------------------------------------------------------------------------
package ldpc_layer_sched_pkg;

    localparam int WIDTH_RATE = 2;
    localparam int WIDTH_LAT  = 4;

    typedef enum logic [1:0] {
        RATE_1_2   = 2'd0,
        RATE_5_8   = 2'd1,
        RATE_3_4   = 2'd2,
        RATE_13_16 = 2'd3
    } rate_e;

    // Indexed by rate_e value.
    localparam int LAYERS_PER_RATE [4] = '{8, 6, 4, 3};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_COPY = 3'd1,
        ST_CHK  = 3'd2,
        ST_VAR  = 3'd3,
        ST_DONE = 3'd4
    } sched_state_e;

    function automatic int layers_for_rate(input logic [1:0] r);
        return LAYERS_PER_RATE[r];
    endfunction

endpackage

// File: rtl/ldpc_layer_sched_dwell_cnt.sv
// ---------------------------------------------------------------------------
// ldpc_dwell_cnt
// Loadable down-counter timing one dwell period (a check-node layer or the
// variable-node phase). Loading value N-1 makes tc_o assert in the N-th cycle
// after the load edge. The counter rests at zero, so tc_o is high when idle.
// Ports:
//   clk        : clock, rising edge
//   rst_n_i    : synchronous active-low reset
//   load_i     : load load_val_i on the next edge (has priority)
//   load_val_i : dwell length minus one
//   tc_o       : terminal count (counter == 0)
// ---------------------------------------------------------------------------
module ldpc_dwell_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         tc_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == '0);

endmodule

// File: rtl/ldpc_layer_sched.sv
// ---------------------------------------------------------------------------
// ldpc_layer_sched
// Layered-decoding scheduler for the 802.11ay LDPC decoder. Sequences the
// LLR copy, per-layer check-node processing and the variable-node update,
// counts iterations, terminates early on a passing syndrome and hands the
// result to the output stage with a done/acknowledge handshake.
// Ports:
//   clk, reset        : clock and synchronous active-low reset
//   validIn/llrInLast : start condition (last LLR beat of a codeword), IDLE only
//   rate, iterMax     : code rate and iteration limit, latched at start
//   chkLatency        : cycles per check-node layer, latched at start (0 -> 1)
//   vnLatency         : cycles of the variable-node phase, latched (0 -> 1)
//   syndrome(Valid)   : parity status, sampled in the last VAR cycle only
//   doneAck           : output stage took the result (DONE only)
//   CurrLayer/CurrIter: layer being processed / 1-based iteration
//   CopyLLRIn2LLRNew, ChkNInputValid, VarNInputValid : phase strobes
//   busy, decodeDone, decodeConverged : status
// ---------------------------------------------------------------------------
module ldpc_layer_sched
    import ldpc_layer_sched_pkg::*;
#(
    parameter int NUM_LAYERS_MAX  = 8,
    parameter int WIDTH_LAYER     = 3,
    parameter int WIDTH_ITERATION = 5,
    parameter int WIDTH_LAT       = ldpc_layer_sched_pkg::WIDTH_LAT,
    parameter int WIDTH_RATE      = ldpc_layer_sched_pkg::WIDTH_RATE
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       validIn,
    input  logic                       llrInLast,
    input  logic [WIDTH_RATE-1:0]      rate,
    input  logic [WIDTH_ITERATION-1:0] iterMax,
    input  logic [WIDTH_LAT-1:0]       chkLatency,
    input  logic [WIDTH_LAT-1:0]       vnLatency,
    input  logic                       syndrome,
    input  logic                       syndromeValid,
    input  logic                       doneAck,
    output logic [WIDTH_LAYER-1:0]     CurrLayer,
    output logic [WIDTH_ITERATION-1:0] CurrIter,
    output logic                       CopyLLRIn2LLRNew,
    output logic                       ChkNInputValid,
    output logic                       VarNInputValid,
    output logic                       busy,
    output logic                       decodeDone,
    output logic                       decodeConverged
);

    sched_state_e               state_q;
    logic [WIDTH_LAYER-1:0]     layer_q;
    logic [WIDTH_LAYER-1:0]     last_layer_q;
    logic [WIDTH_ITERATION-1:0] iter_q;
    logic [WIDTH_ITERATION-1:0] iter_max_q;
    logic [WIDTH_LAT-1:0]       chk_lat_q;
    logic [WIDTH_LAT-1:0]       vn_lat_q;
    logic                       copy_stb_q;
    logic                       chk_stb_q;
    logic                       var_stb_q;
    logic                       converged_q;

    logic                       dwell_load_d;
    logic [WIDTH_LAT-1:0]       dwell_val_d;
    logic                       dwell_tc;
    logic [WIDTH_LAYER-1:0]     start_last_layer_d;
    int                         rate_layers;

    // Layer count of the requested rate, bounded by the layer memory depth.
    always_comb begin
        rate_layers = layers_for_rate(2'(rate));
        if (rate_layers > NUM_LAYERS_MAX) begin
            rate_layers = NUM_LAYERS_MAX;
        end
        start_last_layer_d = WIDTH_LAYER'(rate_layers - 1);
    end

    // The dwell counter is (re)loaded whenever a new dwell period starts:
    // the first layer after COPY, each further layer, the VAR phase and the
    // first layer of a following iteration. Loads toward DONE are harmless.
    always_comb begin
        dwell_load_d = 1'b0;
        dwell_val_d  = chk_lat_q - WIDTH_LAT'(1);
        case (state_q)
            ST_COPY: dwell_load_d = 1'b1;
            ST_CHK: begin
                if (dwell_tc) begin
                    dwell_load_d = 1'b1;
                    if (layer_q == last_layer_q) begin
                        dwell_val_d = vn_lat_q - WIDTH_LAT'(1);
                    end
                end
            end
            ST_VAR:  dwell_load_d = dwell_tc;
            default: dwell_load_d = 1'b0;
        endcase
    end

    ldpc_dwell_cnt #(
        .W (WIDTH_LAT)
    ) u_dwell (
        .clk        (clk),
        .rst_n_i    (reset),
        .load_i     (dwell_load_d),
        .load_val_i (dwell_val_d),
        .tc_o       (dwell_tc)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            layer_q      <= '0;
            last_layer_q <= '0;
            iter_q       <= '0;
            iter_max_q   <= '0;
            chk_lat_q    <= '0;
            vn_lat_q     <= '0;
            copy_stb_q   <= 1'b0;
            chk_stb_q    <= 1'b0;
            var_stb_q    <= 1'b0;
            converged_q  <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-armed below.
            copy_stb_q <= 1'b0;
            chk_stb_q  <= 1'b0;
            var_stb_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (validIn && llrInLast) begin
                        state_q      <= ST_COPY;
                        copy_stb_q   <= 1'b1;
                        last_layer_q <= start_last_layer_d;
                        iter_max_q   <= (iterMax == '0) ? WIDTH_ITERATION'(1) : iterMax;
                        chk_lat_q    <= (chkLatency == '0) ? WIDTH_LAT'(1) : chkLatency;
                        vn_lat_q     <= (vnLatency == '0) ? WIDTH_LAT'(1) : vnLatency;
                    end
                end
                ST_COPY: begin
                    state_q   <= ST_CHK;
                    layer_q   <= '0;
                    iter_q    <= WIDTH_ITERATION'(1);
                    chk_stb_q <= 1'b1;
                end
                ST_CHK: begin
                    if (dwell_tc) begin
                        if (layer_q == last_layer_q) begin
                            // layer_q stays at the last layer through VAR.
                            state_q   <= ST_VAR;
                            var_stb_q <= 1'b1;
                        end else begin
                            layer_q   <= layer_q + WIDTH_LAYER'(1);
                            chk_stb_q <= 1'b1;
                        end
                    end
                end
                ST_VAR: begin
                    if (dwell_tc) begin
                        layer_q <= '0;
                        if (syndromeValid && !syndrome) begin
                            state_q     <= ST_DONE;
                            converged_q <= 1'b1;
                        end else if (iter_q == iter_max_q) begin
                            state_q     <= ST_DONE;
                            converged_q <= 1'b0;
                        end else begin
                            state_q   <= ST_CHK;
                            iter_q    <= iter_q + WIDTH_ITERATION'(1);
                            chk_stb_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (doneAck) begin
                        state_q     <= ST_IDLE;
                        iter_q      <= '0;
                        converged_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign CurrLayer        = layer_q;
    assign CurrIter         = iter_q;
    assign CopyLLRIn2LLRNew = copy_stb_q;
    assign ChkNInputValid   = chk_stb_q;
    assign VarNInputValid   = var_stb_q;
    assign busy             = (state_q == ST_COPY) || (state_q == ST_CHK) || (state_q == ST_VAR);
    assign decodeDone       = (state_q == ST_DONE);
    assign decodeConverged  = converged_q;

endmodule

// File: tb/tb_ldpc_layer_sched.sv
module tb_ldpc_layer_sched;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       validIn = 1'b0;
    logic       llrInLast = 1'b0;
    logic [1:0] rate = 2'd0;
    logic [4:0] iterMax = 5'd0;
    logic [3:0] chkLatency = 4'd0;
    logic [3:0] vnLatency = 4'd0;
    logic       syndrome = 1'b1;
    logic       syndromeValid = 1'b0;
    logic       doneAck = 1'b0;
    logic [2:0] CurrLayer;
    logic [4:0] CurrIter;
    logic       CopyLLRIn2LLRNew;
    logic       ChkNInputValid;
    logic       VarNInputValid;
    logic       busy;
    logic       decodeDone;
    logic       decodeConverged;

    int n_checks = 0;
    int n_fail   = 0;

    ldpc_layer_sched dut (
        .clk              (clk),
        .reset            (reset),
        .validIn          (validIn),
        .llrInLast        (llrInLast),
        .rate             (rate),
        .iterMax          (iterMax),
        .chkLatency       (chkLatency),
        .vnLatency        (vnLatency),
        .syndrome         (syndrome),
        .syndromeValid    (syndromeValid),
        .doneAck          (doneAck),
        .CurrLayer        (CurrLayer),
        .CurrIter         (CurrIter),
        .CopyLLRIn2LLRNew (CopyLLRIn2LLRNew),
        .ChkNInputValid   (ChkNInputValid),
        .VarNInputValid   (VarNInputValid),
        .busy             (busy),
        .decodeDone       (decodeDone),
        .decodeConverged  (decodeConverged)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_decode(input logic [1:0] r, input logic [4:0] it,
                                input logic [3:0] cl, input logic [3:0] vl);
        rate = r; iterMax = it; chkLatency = cl; vnLatency = vl;
        validIn = 1'b1; llrInLast = 1'b1;
        tick();
        validIn = 1'b0; llrInLast = 1'b0;
    endtask

    // From the COPY cycle, run until decodeDone and report what was observed.
    task automatic run_to_done(input bit pulse_start, output int cycles,
                               output int chk_total, output int chk_iter1,
                               output int var_total, output int max_layer,
                               output bit timed_out);
        bit pulsed = 0;
        cycles = 0; chk_total = 0; chk_iter1 = 0; var_total = 0;
        max_layer = 0; timed_out = 0;
        while (decodeDone !== 1'b1) begin
            if (cycles >= 3000) begin
                timed_out = 1;
                break;
            end
            if (pulse_start && !pulsed && ChkNInputValid && CurrLayer == 3'd2) begin
                validIn = 1'b1; llrInLast = 1'b1; rate = 2'd3; iterMax = 5'd9;
                pulsed = 1;
            end
            tick();
            validIn = 1'b0; llrInLast = 1'b0;
            cycles++;
            if (ChkNInputValid) begin
                chk_total++;
                if (CurrIter == 5'd1) chk_iter1++;
            end
            if (VarNInputValid) var_total++;
            if (int'(CurrLayer) > max_layer) max_layer = int'(CurrLayer);
        end
    endtask

    task automatic ack_done();
        doneAck = 1'b1;
        tick();
        doneAck = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({CurrLayer, CurrIter, CopyLLRIn2LLRNew, ChkNInputValid, VarNInputValid,
             busy, decodeDone, decodeConverged} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0",
                     {CurrLayer, CurrIter, CopyLLRIn2LLRNew, ChkNInputValid,
                      VarNInputValid, busy, decodeDone, decodeConverged});
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_start: busy=%b required 0", busy);
        end
    endtask

    task automatic test_max_iter();
        int cyc, ct, c1, vt, ml;
        bit to;
        syndromeValid = 1'b1; syndrome = 1'b1;
        start_decode(2'd0, 5'd2, 4'd4, 4'd1);
        n_checks++;
        if (CopyLLRIn2LLRNew !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL copy_cycle: copy=%b busy=%b required 1 1", CopyLLRIn2LLRNew, busy);
        end
        run_to_done(0, cyc, ct, c1, vt, ml, to);
        n_checks++;
        if (to || cyc != 67) begin
            n_fail++;
            $display("FAIL maxiter_cycles: got %0d (timeout %0d) required 67", cyc, to);
        end
        n_checks++;
        if (c1 != 8 || ct != 16 || vt != 2) begin
            n_fail++;
            $display("FAIL maxiter_pulses: chk_iter1=%0d chk=%0d var=%0d required 8 16 2", c1, ct, vt);
        end
        n_checks++;
        if (CurrIter !== 5'd2 || decodeConverged !== 1'b0 || CurrLayer !== 3'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL maxiter_done: iter=%0d conv=%b layer=%0d busy=%b required 2 0 0 0",
                     CurrIter, decodeConverged, CurrLayer, busy);
        end
        ack_done();
        n_checks++;
        if (decodeDone !== 1'b0) begin
            n_fail++;
            $display("FAIL maxiter_ack: decodeDone=%b required 0", decodeDone);
        end
    endtask

    task automatic test_converge();
        int cyc, ct, c1, vt, ml;
        bit to;
        syndromeValid = 1'b1; syndrome = 1'b0;
        start_decode(2'd3, 5'd10, 4'd4, 4'd1);
        run_to_done(0, cyc, ct, c1, vt, ml, to);
        n_checks++;
        if (to || cyc != 14) begin
            n_fail++;
            $display("FAIL converge_cycles: got %0d (timeout %0d) required 14", cyc, to);
        end
        n_checks++;
        if (CurrIter !== 5'd1 || decodeConverged !== 1'b1 || ct != 3 || ml != 2) begin
            n_fail++;
            $display("FAIL converge_done: iter=%0d conv=%b chk=%0d maxlayer=%0d required 1 1 3 2",
                     CurrIter, decodeConverged, ct, ml);
        end
        ack_done();
        syndrome = 1'b1;
    endtask

    task automatic test_reset_abort();
        int cyc, ct, c1, vt, ml, n;
        bit to;
        bit saw_done = 0;
        syndromeValid = 1'b1; syndrome = 1'b1;
        start_decode(2'd0, 5'd4, 4'd4, 4'd1);
        n = 0;
        while (!(CurrLayer == 3'd3 && busy) && n < 200) begin
            tick();
            n++;
        end
        n_checks++;
        if (n >= 200) begin
            n_fail++;
            $display("FAIL abort_reach_layer3: layer=%0d required 3", CurrLayer);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if ({CurrLayer, CurrIter, CopyLLRIn2LLRNew, ChkNInputValid, VarNInputValid,
             busy, decodeDone, decodeConverged} !== 14'd0) begin
            n_fail++;
            $display("FAIL abort_outputs: got %h required 0",
                     {CurrLayer, CurrIter, CopyLLRIn2LLRNew, ChkNInputValid,
                      VarNInputValid, busy, decodeDone, decodeConverged});
        end
        reset = 1'b1;
        repeat (40) begin
            tick();
            if (decodeDone || busy) saw_done = 1;
        end
        n_checks++;
        if (saw_done) begin
            n_fail++;
            $display("FAIL abort_no_result: activity after abort=%b required 0", saw_done);
        end
        start_decode(2'd2, 5'd1, 4'd2, 4'd2);
        run_to_done(0, cyc, ct, c1, vt, ml, to);
        n_checks++;
        if (to || cyc != 11 || ct != 4 || CurrIter !== 5'd1) begin
            n_fail++;
            $display("FAIL abort_fresh: cycles=%0d chk=%0d iter=%0d required 11 4 1", cyc, ct, CurrIter);
        end
        ack_done();
    endtask

    task automatic test_ignore_start_and_ack();
        int cyc, ct, c1, vt, ml;
        bit to;
        bit held = 1;
        syndromeValid = 1'b0; syndrome = 1'b1;
        start_decode(2'd1, 5'd1, 4'd2, 4'd1);
        run_to_done(1, cyc, ct, c1, vt, ml, to);
        n_checks++;
        if (to || cyc != 14 || ct != 6 || ml != 5 || CurrIter !== 5'd1) begin
            n_fail++;
            $display("FAIL ignore_start: cycles=%0d chk=%0d maxlayer=%0d iter=%0d required 14 6 5 1",
                     cyc, ct, ml, CurrIter);
        end
        repeat (5) begin
            tick();
            if (decodeDone !== 1'b1) held = 0;
        end
        n_checks++;
        if (!held) begin
            n_fail++;
            $display("FAIL done_hold: decodeDone dropped without ack, required held 1");
        end
        ack_done();
        n_checks++;
        if (decodeDone !== 1'b0 || busy !== 1'b0 || CurrIter !== 5'd0) begin
            n_fail++;
            $display("FAIL done_ack_idle: done=%b busy=%b iter=%0d required 0 0 0",
                     decodeDone, busy, CurrIter);
        end
    endtask

    task automatic test_zero_params();
        int cyc, ct, c1, vt, ml;
        bit to;
        syndromeValid = 1'b0; syndrome = 1'b1;
        start_decode(2'd2, 5'd0, 4'd0, 4'd0);
        run_to_done(0, cyc, ct, c1, vt, ml, to);
        n_checks++;
        if (to || cyc != 6 || ct != 4 || vt != 1) begin
            n_fail++;
            $display("FAIL zero_params: cycles=%0d chk=%0d var=%0d required 6 4 1", cyc, ct, vt);
        end
        n_checks++;
        if (CurrIter !== 5'd1 || decodeConverged !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_params_done: iter=%0d conv=%b required 1 0", CurrIter, decodeConverged);
        end
        ack_done();
    endtask

    task automatic test_rate_change();
        int cyc, ct, c1, vt, ml;
        bit to;
        syndromeValid = 1'b0;
        start_decode(2'd0, 5'd1, 4'd1, 4'd1);
        rate = 2'd2;
        run_to_done(0, cyc, ct, c1, vt, ml, to);
        n_checks++;
        if (to || cyc != 10 || ct != 8 || ml != 7) begin
            n_fail++;
            $display("FAIL rate_change: cycles=%0d chk=%0d maxlayer=%0d required 10 8 7", cyc, ct, ml);
        end
        ack_done();
    endtask

    task automatic test_back_to_back();
        int cyc, ct, c1, vt, ml;
        bit to;
        syndromeValid = 1'b1; syndrome = 1'b1;
        start_decode(2'd3, 5'd3, 4'd1, 4'd2);
        run_to_done(0, cyc, ct, c1, vt, ml, to);
        n_checks++;
        if (to || cyc != 16 || ct != 9 || CurrIter !== 5'd3) begin
            n_fail++;
            $display("FAIL back_to_back: cycles=%0d chk=%0d iter=%0d required 16 9 3", cyc, ct, CurrIter);
        end
        ack_done();
    endtask

    initial begin
        test_reset();
        test_max_iter();
        test_converge();
        test_reset_abort();
        test_ignore_start_and_ack();
        test_zero_params();
        test_rate_change();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
